// File: rtl/fetch_pkg.sv
// Shared pipeline types for the fetch stage: buffered entry layout, reset PC
// and instruction-bus field widths.
package fetch_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam int IBUS_ADDR_W = 64;
    localparam int IBUS_DATA_W = 32;

    localparam u64 PCINIT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        u64 pc;
        u32 instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^64.
    function automatic u64 pc_next(input u64 pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small shift-style FIFO holding fetched {pc, instr} pairs for decode, plus a
// checker module that flags any push into a full buffer without a pop.
module fetch_buffer_checker #(
    parameter int DEPTH = 1,
    parameter int CNT_W = 1
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic             flush,
    input logic [CNT_W-1:0] count
);

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

endmodule

module fetch_buffer import fetch_pkg::*; #(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     entry_in,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_r   [DEPTH];
    fetch_entry_t     shift_s [DEPTH];
    fetch_entry_t     next_s  [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] wr_idx_s;
    logic             pop_s;

    // Next storage image: shift toward the head on pop, then write the tail slot.
    always_comb begin
        pop_s    = pop && (count_r != {CNT_W{1'b0}});
        wr_idx_s = count_r - CNT_W'(pop_s);
        for (int i = 0; i < DEPTH; i++) begin
            shift_s[i] = mem_r[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_s ? mem_r[i + 1] : mem_r[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            next_s[i] = (push && (int'(wr_idx_s) == i)) ? entry_in : shift_s[i];
        end
    end

    // Storage and occupancy; flush empties the buffer without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= next_s[i];
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop_s);
        end
    end

    assign count = count_r;
    assign head  = mem_r[0];

    fetch_buffer_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop_s),
        .flush (flush),
        .count (count_r)
    );

endmodule

// File: rtl/fetch.sv
// RV64 instruction-fetch stage: one outstanding bus read, buffered words to
// decode, redirect with drop of in-flight data. FETCH_PREFETCH_EN selects DEPTH=2.
module fetch import fetch_pkg::*; #(
    parameter logic [IBUS_ADDR_W-1:0] PC_INIT = PCINIT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [IBUS_ADDR_W-1:0] ireq_addr,
    input  logic                   iresp_data_ok,
    input  logic [IBUS_DATA_W-1:0] iresp_data,
    input  logic                   redirect_valid,
    input  logic [IBUS_ADDR_W-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_pc,
    output logic [31:0]            out_instr
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IBUS_ADDR_W-1:0] fpc_r;
    logic [IBUS_ADDR_W-1:0] addr_r;
    logic                   inflight_r;
    logic                   drop_r;

    logic [CNT_W-1:0]       count_s;
    fetch_entry_t           head_s;
    fetch_entry_t           push_entry_s;
    logic                   pop_s;
    logic                   done_s;
    logic                   push_s;
    logic                   bus_free_s;
    logic                   room_s;
    logic [IBUS_ADDR_W-1:0] fpc_adv_s;

    // Completion, push and issue qualification; room is judged after this cycle's pop and push.
    always_comb begin
        pop_s        = (count_s != {CNT_W{1'b0}}) && out_ready;
        done_s       = inflight_r && iresp_data_ok;
        push_s       = done_s && !drop_r && !redirect_valid;
        bus_free_s   = !inflight_r || iresp_data_ok;
        fpc_adv_s    = push_s ? pc_next(addr_r) : fpc_r;
        room_s       = (int'(count_s) + int'(push_s) - int'(pop_s) + 1) <= DEPTH;
        push_entry_s = '{pc: addr_r, instr: iresp_data};
    end

    // Fetch PC and bus request state; the address is frozen while a request is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_r      <= PC_INIT;
            addr_r     <= PC_INIT;
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end else if (redirect_valid) begin
            fpc_r <= redirect_pc;
            if (bus_free_s) begin
                inflight_r <= 1'b1;
                addr_r     <= redirect_pc;
                drop_r     <= 1'b0;
            end else begin
                drop_r <= 1'b1;
            end
        end else if (bus_free_s && room_s) begin
            inflight_r <= 1'b1;
            addr_r     <= fpc_adv_s;
            fpc_r      <= fpc_adv_s;
            drop_r     <= 1'b0;
        end else begin
            inflight_r <= inflight_r && !iresp_data_ok;
            fpc_r      <= fpc_adv_s;
            drop_r     <= drop_r && !iresp_data_ok;
        end
    end

    fetch_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .entry_in (push_entry_s),
        .pop      (pop_s),
        .flush    (redirect_valid),
        .count    (count_s),
        .head     (head_s)
    );

    assign ireq_valid = inflight_r;
    assign ireq_addr  = addr_r;
    assign out_valid  = (count_s != {CNT_W{1'b0}});
    assign out_pc     = head_s.pc;
    assign out_instr  = head_s.instr;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus a randomized bus/decode
// run checked against an architectural instruction-stream model.
module tb_fetch;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int tests_run;
    int tests_failed;

    fetch #(.PC_INIT(PC_INIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Contents of instruction memory as seen by the bench's bus responder.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        iresp_data_ok = 1'b0;
        iresp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ireq_valid !== 1'b0 || ireq_addr !== PC_INIT) begin
            tests_failed++;
            $display("FAIL reset_bus: got valid=%b addr=%h, expected 0 %h", ireq_valid, ireq_addr, PC_INIT);
        end
        tests_run++;
        if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out: got valid=%b pc=%h instr=%h, expected all 0", out_valid, out_pc, out_instr);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_INIT) begin
            tests_failed++;
            $display("FAIL first_req: got valid=%b addr=%h, expected 1 %h", ireq_valid, ireq_addr, PC_INIT);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_addr;
        logic [63:0] prev_addr;
        bit          ok_prev;
        int          n_ok;
        do_reset();
        out_ready = 1'b1;
        exp_addr = PC_INIT;
        prev_addr = 64'h0;
        ok_prev = 1'b0;
        n_ok = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ok_prev) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_pc !== prev_addr || out_instr !== 32'h0000_0013) begin
                    tests_failed++;
                    $display("FAIL stream_out: got valid=%b pc=%h instr=%h, expected 1 %h 00000013",
                             out_valid, out_pc, out_instr, prev_addr);
                end
            end
            if (ireq_valid) begin
                tests_run++;
                if (ireq_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL stream_addr: got %h expected %h", ireq_addr, exp_addr);
                end
                prev_addr = ireq_addr;
                exp_addr = exp_addr + 64'd4;
                iresp_data_ok = 1'b1;
                iresp_data = 32'h0000_0013;
                ok_prev = 1'b1;
                n_ok++;
            end else begin
                iresp_data_ok = 1'b0;
                ok_prev = 1'b0;
            end
        end
        tests_run++;
        if (n_ok != ((DEPTH == 2) ? 12 : 6)) begin
            tests_failed++;
            $display("FAIL stream_rate: got %0d completions expected %0d", n_ok, (DEPTH == 2) ? 12 : 6);
        end
    endtask

    task automatic test_stall();
        int n_ok;
        do_reset();
        out_ready = 1'b0;
        n_ok = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c > 0) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_pc !== PC_INIT || out_instr !== mem_word(PC_INIT)) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                             out_valid, out_pc, out_instr, PC_INIT, mem_word(PC_INIT));
                end
            end
            if (ireq_valid) begin
                iresp_data_ok = 1'b1;
                iresp_data = mem_word(ireq_addr);
                n_ok++;
            end else begin
                iresp_data_ok = 1'b0;
            end
        end
        tests_run++;
        if (n_ok != DEPTH || ireq_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d completions valid=%b, expected %0d and 0", n_ok, ireq_valid, DEPTH);
        end
        // Idle bus: a redirect (unaligned low bits) goes straight onto the bus next cycle.
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_9000_0122;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0000_0000_9000_0122 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_redirect: got valid=%b addr=%h out_valid=%b, expected 1 0000000090000122 0",
                     ireq_valid, ireq_addr, out_valid);
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        iresp_data_ok = 1'b1;
        iresp_data = mem_word(PC_INIT);
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            iresp_data_ok = 1'b0;
            found = ireq_valid && (ireq_addr == PC_INIT + 64'd4);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL redir_setup: got addr=%h expected %h within 6 cycles", ireq_addr, PC_INIT + 64'd4);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            tests_run++;
            if (ireq_valid !== 1'b1 || ireq_addr !== PC_INIT + 64'd4 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL redir_hold: got valid=%b addr=%h out_valid=%b, expected 1 %h 0",
                         ireq_valid, ireq_addr, out_valid, PC_INIT + 64'd4);
            end
            if (k == 2) begin
                iresp_data_ok = 1'b1;
                iresp_data = mem_word(PC_INIT + 64'd4);
            end
        end
        @(negedge clk);
        tests_run++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0000_0000_8000_1000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_next: got valid=%b addr=%h out_valid=%b, expected 1 0000000080001000 0",
                     ireq_valid, ireq_addr, out_valid);
        end
        iresp_data = mem_word(64'h0000_0000_8000_1000);
        @(negedge clk);
        iresp_data_ok = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0000_0000_8000_1000 || out_instr !== mem_word(64'h0000_0000_8000_1000)) begin
            tests_failed++;
            $display("FAIL redir_word: got valid=%b pc=%h instr=%h, expected 1 0000000080001000 %h",
                     out_valid, out_pc, out_instr, mem_word(64'h0000_0000_8000_1000));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        iresp_data_ok = 1'b1;
        iresp_data = mem_word(PC_INIT);
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_2000;
        @(negedge clk);
        iresp_data_ok = 1'b0;
        redirect_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h0000_0000_8000_2000) begin
            tests_failed++;
            $display("FAIL same_cycle_redir: got out_valid=%b valid=%b addr=%h, expected 0 1 0000000080002000",
                     out_valid, ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        iresp_data_ok = 1'b1;
        iresp_data = mem_word(PC_INIT);
        repeat (2) begin
            @(negedge clk);
            iresp_data_ok = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (ireq_valid !== 1'b0 || out_valid !== 1'b0 || ireq_addr !== PC_INIT) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b out_valid=%b addr=%h, expected 0 0 %h",
                     ireq_valid, out_valid, ireq_addr, PC_INIT);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_INIT) begin
            tests_failed++;
            $display("FAIL reset_restart: got valid=%b addr=%h, expected 1 %h", ireq_valid, ireq_addr, PC_INIT);
        end
    endtask

    task automatic test_wrap();
        bit found;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data = mem_word(PC_INIT);
        @(negedge clk);
        tests_run++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_req: got valid=%b addr=%h, expected 1 fffffffffffffffc", ireq_valid, ireq_addr);
        end
        iresp_data_ok = 1'b1;
        iresp_data = mem_word(64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        iresp_data_ok = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_out: got valid=%b pc=%h, expected 1 fffffffffffffffc", out_valid, out_pc);
        end
        found = ireq_valid;
        for (int c = 0; c < 3 && !found; c++) begin
            @(negedge clk);
            found = ireq_valid;
        end
        tests_run++;
        if (!found || ireq_addr !== 64'h0) begin
            tests_failed++;
            $display("FAIL wrap_addr: got valid=%b addr=%h, expected 1 0000000000000000", found, ireq_addr);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] pend_addr;
        bit          busy;
        bit          pend;
        int          lat;
        int          pops;
        do_reset();
        exp_pc = PC_INIT;
        pend_addr = 64'h0;
        busy = 1'b0;
        pend = 1'b0;
        lat = 0;
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pend) begin
                tests_run++;
                if (ireq_valid !== 1'b1 || ireq_addr !== pend_addr) begin
                    tests_failed++;
                    $display("FAIL rnd_bus_stable: got valid=%b addr=%h, expected 1 %h", ireq_valid, ireq_addr, pend_addr);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = {32'h0000_0000, $urandom() & 32'hFFFF_FFFC};
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL rnd_stream: got pc=%h instr=%h, expected %h %h", out_pc, out_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            if (ireq_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data = mem_word(ireq_addr);
                    busy = 1'b0;
                end else begin
                    iresp_data_ok = 1'b0;
                    lat--;
                end
            end else begin
                iresp_data_ok = 1'b0;
            end
            pend = ireq_valid && !iresp_data_ok;
            pend_addr = ireq_addr;
        end
        @(negedge clk);
        iresp_data_ok = 1'b0;
        redirect_valid = 1'b0;
        tests_run++;
        if (pops <= 100) begin
            tests_failed++;
            $display("FAIL rnd_progress: got %0d instructions, expected more than 100", pops);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        iresp_data_ok = 1'b0;
        iresp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        out_ready = 1'b0;
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV64 pipeline, directly upstream of instruction decode. Holds the fetch PC and issues 32-bit instruction reads on the instruction bus. Buffers returned words and presents them to decode, together with their PC, under a valid/ready handshake. Handles control-flow redirects from later stages, including redirects that arrive while a bus request is outstanding.

## Interface
- `PC_INIT`, default 64'h0000_0000_8000_0000: fetch PC after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ireq_valid`  out  1  instruction bus request.
- `ireq_addr`  out  64  request address.
- `iresp_data_ok`  in  1  response valid this cycle; completes the request.
- `iresp_data`  in  32  instruction word, valid when `iresp_data_ok`=1.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  64  new fetch PC.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts this cycle.
- `out_pc`  out  64  PC of the presented instruction.
- `out_instr`  out  32  raw instruction word; this is decode's `raw_instr`.

## Operation
- **Registers:** fetch PC `fpc`; buffer of `DEPTH` entries, each holding {pc, instr}; `count`; `inflight` flag; `drop` flag.
- **Issue rule:**
  - `ireq_valid` = `inflight`.
  - A new request starts (`inflight`←1, `ireq_addr`=`fpc`) when `!inflight`, `!redirect_valid`, and (`count` + 1) ≤ `DEPTH` after this cycle's pop.
- **Bus rule:** once `ireq_valid`=1, `ireq_valid` and `ireq_addr` stay stable until the cycle with `iresp_data_ok`=1, even across a redirect.
- **On data_ok:**
  - `inflight`←0.
  - If `drop`=0: push {`ireq_addr`, `iresp_data`} and set `fpc`←`ireq_addr`+4 (64-bit wrap).
  - If `drop`=1: discard the data and clear `drop`.
- **Output:** head entry. `out_valid` = (`count`≠0). Pop on `out_valid` & `out_ready`.
- **Redirect (priority over everything else):**
  - Buffer flushed, so `count`←0 next cycle.
  - `fpc`←`redirect_pc`.
  - If a request is outstanding and not completing this cycle, `drop`←1.
  - A request completing in the same cycle as the redirect is discarded.
  - A pop in the same cycle is still taken as consumed by decode.
  - `redirect_pc` is not alignment-checked; bits [1:0] pass through to `ireq_addr`.
- **Buffer:** FIFO. Simultaneous push and pop at `count`=`DEPTH` is legal because issue is gated on post-pop occupancy. Overflow cannot occur; if it would, that is an assertion failure.

## Timing
- **Reset values:**
  - `fpc`=`PC_INIT`; `count`=0; `inflight`=0; `drop`=0.
  - `ireq_valid`=0; `ireq_addr`=`PC_INIT`.
  - `out_valid`=0; `out_pc`=0; `out_instr`=0.
- **After reset:** first cycle after deassert, `ireq_valid`=1 with `ireq_addr`=`PC_INIT`.
- **Latency:** `iresp_data_ok` in cycle N gives `out_valid`=1 in cycle N+1. There is no combinational bypass from the bus to `out_*`.
- **Next request:** may begin in cycle N+1 when there is room, so back-to-back one-cycle responses give one instruction per cycle with `DEPTH`=2.
- **Redirect in cycle R with idle bus:** `ireq_valid`=1, `ireq_addr`=`redirect_pc` in cycle R+1.
- **Redirect in cycle R with request outstanding:** the old address stays on the bus until data_ok in cycle M. The new request issues in M+1.
- **Reset mid-request:** all state clears immediately. The bus is reset concurrently.

## Configuration
- `FETCH_PREFETCH_EN` defined: `DEPTH`=2. Fetch of the next instruction overlaps a decode stall.
- `FETCH_PREFETCH_EN` undefined: `DEPTH`=1. A new request issues only once the single entry is free or being popped this cycle.

## Structure
- Shared pipeline package:
  - `fetch_entry_t` {`u64 pc`; `u32 instr`}.
  - `PCINIT` constant.
  - `ibus` request/response field widths.
- Sub-module `fetch_buffer` (parameter `DEPTH`): push/pop/flush FIFO with `count`, head output, and an overflow assertion.

## Test plan
- Reset, then one-cycle responses of 32'h00000013 and `out_ready`=1 → `ireq_addr` sequence 80000000, 80000004, 80000008; `out_pc` follows one cycle behind each data_ok.
- `out_ready`=0 for 5 cycles → with `DEPTH`=2, exactly 2 requests complete and then `ireq_valid` stays 0; with `DEPTH`=1, exactly 1. `out_instr` stays stable.
- Redirect to 80001000 while a request to 80000004 is outstanding and data_ok arrives 3 cycles later → `ireq_addr` holds 80000004 until data_ok; that word is never presented; the next request is 80001000.
- Redirect in the same cycle as data_ok and `out_ready` → the returned word is dropped, `out_valid`=0 next cycle, next request is `redirect_pc`.
- Reset asserted mid-request → `ireq_valid` and `out_valid` go 0 asynchronously; after release, the request restarts at 80000000.
- `fpc`=FFFFFFFFFFFFFFFC, then data_ok → next `ireq_addr`=0.
